// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state type, frame length and baud divisor math.
// Define UART_TX_PARITY_EN to add an even-parity bit to every frame.
package uart_pkg;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

`ifdef UART_TX_PARITY_EN
  localparam int unsigned FRAME_BITS = 11;
`else
  localparam int unsigned FRAME_BITS = 10;
`endif

  // Truncating divide; the receiver uses the same value so both ends agree on bit time.
  function automatic int symbol_edge_time(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_transmitter_if.sv
// Byte-level ready/valid link between a producer and the UART transmitter.
interface uart_transmitter_if;

  logic [7:0] data_in;
  logic       data_in_valid;
  logic       data_in_ready;

  modport master (
    output data_in,
    output data_in_valid,
    input  data_in_ready
  );

  modport slave (
    input  data_in,
    input  data_in_valid,
    output data_in_ready
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period timer: one-cycle tick on the last cycle of each symbol while enabled.
module uart_baud_tick #(
  parameter int SYMBOL_EDGE_TIME = 1085
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = $clog2(SYMBOL_EDGE_TIME) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);

  logic [CNT_W-1:0] count;

  assign tick = en && (count == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (!en || tick) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmit side: ready/valid byte in, 8N1 frame out (8E1 with UART_TX_PARITY_EN).
// rst is asynchronous active-low; serial_out and data_in_ready are registered.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic                clk,
  input  logic                rst,
  uart_transmitter_if.slave   bus,
  output logic                serial_out
);

  localparam int SYMBOL_EDGE_TIME = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
  localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

  state_t                state;
  logic [FRAME_BITS-1:0] shift_reg;
  logic [3:0]            bit_idx;
  logic                  ready;
  logic                  baud_en;
  logic                  tick;
  logic                  accept;

  function automatic logic [FRAME_BITS-1:0] frame_load(input logic [7:0] data);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^data, data, 1'b0};
`else
    return {1'b1, data, 1'b0};
`endif
  endfunction

  assign bus.data_in_ready = ready;
  assign accept            = bus.data_in_valid && ready;
  assign baud_en           = (state == SEND);

  uart_baud_tick #(
    .SYMBOL_EDGE_TIME(SYMBOL_EDGE_TIME)
  ) u_baud_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (baud_en),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bit_idx    <= '0;
      ready      <= 1'b1;
      serial_out <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          serial_out <= 1'b1;
          if (accept) begin
            shift_reg  <= frame_load(bus.data_in);
            bit_idx    <= '0;
            ready      <= 1'b0;
            // Start bit goes out straight away rather than waiting for the load.
            serial_out <= 1'b0;
            state      <= SEND;
          end
        end
        SEND: begin
          if (tick) begin
            if (bit_idx == LAST_BIT) begin
              ready      <= 1'b1;
              serial_out <= 1'b1;
              state      <= IDLE;
            end else begin
              shift_reg  <= {1'b1, shift_reg[FRAME_BITS-1:1]};
              serial_out <= shift_reg[1];
              bit_idx    <= bit_idx + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter at 50 MHz / 115200 baud (434 clocks per bit).
module tb_uart_transmitter;

  localparam int SET = 50_000_000 / 115_200;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        serial_out;
  int          nvec = 0;
  int          nmis = 0;
  int unsigned cyc  = 0;

  uart_transmitter_if bus ();

  uart_transmitter #(
    .CLOCK_FREQ(50_000_000),
    .BAUD_RATE (115_200)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .serial_out (serial_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Line image of one frame, bit k occupying clocks k*SET .. k*SET+SET-1.
  function automatic logic [NBITS-1:0] model_frame(input logic [7:0] b);
    logic [NBITS-1:0] f;
    for (int k = 0; k < NBITS; k++) begin
      if (k == 0)              f[k] = 1'b0;
      else if (k <= 8)         f[k] = b[k-1];
      else if (k == NBITS - 1) f[k] = 1'b1;
      else                     f[k] = ^b;
    end
    return f;
  endfunction

  task automatic start_byte(input logic [7:0] b, input bit hold, output int unsigned t0);
    int w;
    w = 0;
    while (bus.data_in_ready !== 1'b1 && w < 20000) begin
      @(negedge clk);
      w++;
    end
    nvec++;
    if (w >= 20000) begin
      nmis++;
      $display("FAIL ready_wait: data_in_ready=%b, required 1 within 20000 cycles", bus.data_in_ready);
    end
    bus.data_in       = b;
    bus.data_in_valid = 1'b1;
    @(negedge clk);
    if (!hold) bus.data_in_valid = 1'b0;
    t0 = cyc;
  endtask

  // Entered at the first cycle after acceptance; leaves at the first idle cycle after the stop bit.
  task automatic frame_check(input logic [7:0] b, input bit disturb, input string tag,
                             output logic [NBITS-1:0] samp);
    logic [NBITS-1:0] want;
    int line_bad, rdy_bad;
    want = model_frame(b);
    line_bad = 0;
    rdy_bad  = 0;
    samp     = '0;
    for (int c = 0; c < NBITS * SET; c++) begin
      if (serial_out !== want[c / SET]) line_bad++;
      if (bus.data_in_ready !== 1'b0) rdy_bad++;
      if (c % SET == SET / 2) samp[c / SET] = serial_out;
      if (disturb && c == 2000) begin
        bus.data_in       = 8'h3C;
        bus.data_in_valid = 1'b1;
      end
      if (disturb && c == 2010) bus.data_in_valid = 1'b0;
      @(negedge clk);
    end
    nvec++;
    if (line_bad != 0) begin
      nmis++;
      $display("FAIL %s_line: %0d cycles off the expected waveform, required 0", tag, line_bad);
    end
    nvec++;
    if (rdy_bad != 0) begin
      nmis++;
      $display("FAIL %s_ready_low: %0d frame cycles with ready!=0, required 0", tag, rdy_bad);
    end
    nvec++;
    if (samp !== want) begin
      nmis++;
      $display("FAIL %s_midbits: sampled %b, required %b", tag, samp, want);
    end
    nvec++;
    if (samp[8:1] !== b) begin
      nmis++;
      $display("FAIL %s_decode: got %h, required %h", tag, samp[8:1], b);
    end
    nvec++;
    if (serial_out !== 1'b1 || bus.data_in_ready !== 1'b1) begin
      nmis++;
      $display("FAIL %s_end: line=%b ready=%b, required 1/1", tag, serial_out, bus.data_in_ready);
    end
  endtask

  task automatic idle_check(input int n, input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      if (serial_out !== 1'b1 || bus.data_in_ready !== 1'b1) bad++;
      @(negedge clk);
    end
    nvec++;
    if (bad != 0) begin
      nmis++;
      $display("FAIL %s_idle: %0d cycles not idle, required 0", tag, bad);
    end
  endtask

  task automatic test_reset();
    rst               = 1'b0;
    bus.data_in       = 8'h00;
    bus.data_in_valid = 1'b0;
    repeat (10) @(negedge clk);
    nvec++;
    if (serial_out !== 1'b1 || bus.data_in_ready !== 1'b1) begin
      nmis++;
      $display("FAIL reset_hold: line=%b ready=%b, required 1/1", serial_out, bus.data_in_ready);
    end
    rst = 1'b1;
    @(negedge clk);
    nvec++;
    if (serial_out !== 1'b1 || bus.data_in_ready !== 1'b1) begin
      nmis++;
      $display("FAIL reset_release: line=%b ready=%b, required 1/1", serial_out, bus.data_in_ready);
    end
    idle_check(1000, "reset");
  endtask

  task automatic test_single_byte();
    int unsigned t0;
    logic [NBITS-1:0] samp;
    start_byte(8'hA5, 1'b0, t0);
    frame_check(8'hA5, 1'b0, "a5", samp);
    nvec++;
    if (samp[8:0] !== 9'b101001010) begin
      nmis++;
      $display("FAIL a5_pattern: sampled %b, required 101001010", samp[8:0]);
    end
  endtask

  task automatic test_back_to_back();
    int unsigned ta, tb;
    logic [NBITS-1:0] samp;
    start_byte(8'h00, 1'b1, ta);
    bus.data_in = 8'hFF;
    frame_check(8'h00, 1'b0, "b2b_00", samp);
    @(negedge clk);
    tb = cyc;
    bus.data_in_valid = 1'b0;
    nvec++;
    if (tb - ta != NBITS * SET + 1) begin
      nmis++;
      $display("FAIL b2b_spacing: %0d cycles between starts, required %0d", tb - ta, NBITS * SET + 1);
    end
    frame_check(8'hFF, 1'b0, "b2b_ff", samp);
    idle_check(20, "b2b");
  endtask

  task automatic test_data_stability();
    int unsigned t0;
    logic [NBITS-1:0] samp;
    start_byte(8'hC3, 1'b0, t0);
    frame_check(8'hC3, 1'b1, "stable", samp);
    idle_check(50, "stable");
  endtask

  task automatic test_reset_mid_frame();
    int unsigned t0;
    logic [NBITS-1:0] samp;
    start_byte(8'h81, 1'b0, t0);
    repeat (4 * SET + 100) @(negedge clk);
    nvec++;
    if (serial_out !== 1'b0) begin
      nmis++;
      $display("FAIL midrst_pre: line=%b in bit 4 of 81, required 0", serial_out);
    end
    rst = 1'b0;
    #1;
    nvec++;
    if (serial_out !== 1'b1 || bus.data_in_ready !== 1'b1) begin
      nmis++;
      $display("FAIL midrst_async: line=%b ready=%b, required 1/1", serial_out, bus.data_in_ready);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    idle_check(2 * SET, "midrst");
    start_byte(8'h81, 1'b0, t0);
    frame_check(8'h81, 1'b0, "midrst_81", samp);
  endtask

  task automatic test_random();
    int unsigned t0;
    logic [NBITS-1:0] samp;
    logic [7:0] b;
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 30)) @(negedge clk);
      start_byte(b, 1'b0, t0);
      frame_check(b, 1'b0, "rand", samp);
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    int unsigned t0;
    logic [NBITS-1:0] samp;
    start_byte(8'h07, 1'b0, t0);
    frame_check(8'h07, 1'b0, "par07", samp);
    nvec++;
    if (samp[9] !== 1'b1) begin
      nmis++;
      $display("FAIL par07_bit: parity=%b, required 1", samp[9]);
    end
    start_byte(8'h03, 1'b0, t0);
    frame_check(8'h03, 1'b0, "par03", samp);
    nvec++;
    if (samp[9] !== 1'b0) begin
      nmis++;
      $display("FAIL par03_bit: parity=%b, required 0", samp[9]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_data_stability();
    test_reset_mid_frame();
    test_random();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
